// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle of the async FIFO pointer stage.
//   winc        producer write request
//   rptr        Gray read pointer from the read domain (asynchronous to clk)
//   waddr       write address to fifomem
//   wen         write enable to fifomem (winc & ~full)
//   wptr        registered Gray write pointer to the read domain
//   full        registered full flag
//   wcount      registered fill level seen from the write domain
//   almost_full registered, wcount >= AFULL_LEVEL
//   overflow    sticky write-while-full error
// slave is the pointer stage, master is the producer / surrounding logic.
interface fifo_wptr_full_if #(
  parameter int unsigned ADDRSIZE = 3
);
  logic                winc;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE-1:0] waddr;
  logic                wen;
  logic [ADDRSIZE:0]   wptr;
  logic                full;
  logic [ADDRSIZE:0]   wcount;
  logic                almost_full;
  logic                overflow;

  modport master (
    output winc, rptr,
    input  waddr, wen, wptr, full, wcount, almost_full, overflow
  );

  modport slave (
    input  winc, rptr,
    output waddr, wen, wptr, full, wcount, almost_full, overflow
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag stage of the async FIFO.
// Keeps the binary/Gray write pointer, synchronises the read Gray pointer with
// two flops and derives full, fill count, almost-full and overflow.
// Ports:
//   clk  write-domain clock
//   rst  synchronous active-high reset
//   bus  fifo_wptr_full_if.slave (winc, rptr in; waddr, wen, wptr, full,
//        wcount, almost_full, overflow out)
// Build option: define FIFO_OVERFLOW_EN to get the sticky overflow flag;
// otherwise overflow is tied low.
module fifo_wptr_full #(
  parameter int unsigned ADDRSIZE    = 3,
  parameter int unsigned AFULL_LEVEL = 6
) (
  input logic                clk,
  input logic                rst,
  fifo_wptr_full_if.slave    bus
);
  localparam int unsigned PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AFullLvl = PW'(AFULL_LEVEL);

  logic [PW-1:0] wbin_q, wptr_q, wcount_q;
  logic [PW-1:0] wq1_q, wq2_q;
  logic          full_q, afull_q;

  logic          wen;
  logic [PW-1:0] wbin_d, wgray_d, rbin_s, count_d;
  logic          full_d, afull_d;

  assign wen = bus.winc & ~full_q;

  always_comb begin
    wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, wen};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    rbin_s  = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rbin_s[i] = ^(wq2_q >> i);
    end
    count_d = wbin_d - rbin_s;
    afull_d = (count_d >= AFullLvl);
    // Full when write pointer is exactly one lap ahead of the synced read pointer.
    full_d  = (wgray_d == {~wq2_q[ADDRSIZE:ADDRSIZE-1], wq2_q[ADDRSIZE-2:0]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wcount_q <= '0;
      wq1_q    <= '0;
      wq2_q    <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wgray_d;
      wcount_q <= count_d;
      wq1_q    <= bus.rptr;
      wq2_q    <= wq1_q;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

`ifdef FIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;

  assign overflow_d = overflow_q | (bus.winc & full_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.waddr       = wbin_q[ADDRSIZE-1:0];
  assign bus.wen         = wen;
  assign bus.wptr        = wptr_q;
  assign bus.full        = full_q;
  assign bus.wcount      = wcount_q;
  assign bus.almost_full = afull_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
module tb_fifo_wptr_full;
`ifdef FIFO_OVERFLOW_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic clk, rst;
  fifo_wptr_full_if #(.ADDRSIZE(3)) bus ();

  fifo_wptr_full #(.ADDRSIZE(3), .AFULL_LEVEL(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer counts of words written and read (mod 16).
  int m_wr, m_h1, m_h2, m_cnt, rd_bin;
  bit m_full, m_ovf;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic mstep(input bit r, input bit w);
    logic [3:0] pw;
    bit acc;
    if (r) rd_bin = 0;
    rst = r;
    bus.winc = w;
    bus.rptr = 4'(gray(rd_bin));
    #1;
    if (!r) begin
      check("wen", {31'd0, bus.wen}, {31'd0, w && !m_full});
      check("waddr_pre", {29'd0, bus.waddr}, m_wr % 8);
    end
    pw = bus.wptr;
    @(posedge clk);
    if (r) begin
      m_wr = 0; m_h1 = 0; m_h2 = 0; m_cnt = 0; m_full = 0; m_ovf = 0;
    end else begin
      acc = w && !m_full;
      if (w && m_full && OvfEn) m_ovf = 1;
      m_wr   = (m_wr + int'(acc)) % 16;
      m_cnt  = (m_wr - m_h2 + 16) % 16;   // reader position seen two edges late
      m_full = (m_cnt == 8);
      m_h2   = m_h1;
      m_h1   = rd_bin;
    end
    #1;
    check("wptr", {28'd0, bus.wptr}, gray(m_wr));
    check("full", {31'd0, bus.full}, {31'd0, m_full});
    check("wcount", {28'd0, bus.wcount}, m_cnt);
    check("almost_full", {31'd0, bus.almost_full}, {31'd0, m_cnt >= 6});
    check("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
    if (!r) check("wptr_onebit", {31'd0, $countones(pw ^ bus.wptr) <= 1}, 32'd1);
    @(negedge clk);
  endtask

  typedef struct {
    bit         rst;
    bit         winc;
    logic [3:0] rptr;
    bit         pre_ok;
    bit         wen;
    logic [2:0] waddr;
    logic [3:0] wptr;
    bit         full;
    logic [3:0] wcount;
    bit         afull;
    bit         ovf;
  } vec_t;

  function automatic vec_t mk(bit r, bit w, logic [3:0] rp, bit pok, bit we, logic [2:0] wa,
                              logic [3:0] wp, bit f, logic [3:0] wc, bit af, bit ov);
    vec_t v;
    v.rst = r; v.winc = w; v.rptr = rp; v.pre_ok = pok; v.wen = we; v.waddr = wa;
    v.wptr = wp; v.full = f; v.wcount = wc; v.afull = af; v.ovf = ov;
    return v;
  endfunction

  initial begin
    vec_t       tbl[12];
    logic [3:0] gl[8];
    bit         dr_full[3];
    int         dr_cnt[3];
    int         writes, wraps, rate;

    gl = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    tbl[0] = mk(1, 0, 4'd0, 0, 0, 3'd0, 4'd0, 0, 4'd0, 0, 0);
    tbl[1] = mk(1, 0, 4'd0, 1, 0, 3'd0, 4'd0, 0, 4'd0, 0, 0);
    for (int n = 1; n <= 8; n++) begin
      tbl[n+1] = mk(0, 1, 4'd0, 1, 1, 3'(n-1), gl[n-1], n == 8, 4'(n), n >= 6, 0);
    end
    // Write while full: dropped; overflow only when the feature is built in.
    tbl[10] = mk(0, 1, 4'd0, 1, 0, 3'd0, 4'b1100, 1, 4'd8, 1, OvfEn);
    tbl[11] = mk(0, 0, 4'd0, 1, 0, 3'd0, 4'b1100, 1, 4'd8, 1, OvfEn);

    rst = 1'b1; bus.winc = 1'b0; bus.rptr = '0;
    m_wr = 0; m_h1 = 0; m_h2 = 0; m_cnt = 0; m_full = 0; m_ovf = 0; rd_bin = 0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; bus.winc = tbl[i].winc; bus.rptr = tbl[i].rptr;
      #1;
      check($sformatf("t%0d_wen", i), {31'd0, bus.wen}, {31'd0, tbl[i].wen});
      if (tbl[i].pre_ok) check($sformatf("t%0d_waddr", i), {29'd0, bus.waddr}, {29'd0, tbl[i].waddr});
      @(posedge clk); #1;
      check($sformatf("t%0d_wptr", i), {28'd0, bus.wptr}, {28'd0, tbl[i].wptr});
      check($sformatf("t%0d_full", i), {31'd0, bus.full}, {31'd0, tbl[i].full});
      check($sformatf("t%0d_wcount", i), {28'd0, bus.wcount}, {28'd0, tbl[i].wcount});
      check($sformatf("t%0d_afull", i), {31'd0, bus.almost_full}, {31'd0, tbl[i].afull});
      check($sformatf("t%0d_ovf", i), {31'd0, bus.overflow}, {31'd0, tbl[i].ovf});
      @(negedge clk);
    end

    // Drain: reader jumps to 4 (Gray 0110); full clears on the third edge.
    dr_full = '{1'b1, 1'b1, 1'b0};
    dr_cnt  = '{8, 8, 4};
    rst = 1'b0; bus.winc = 1'b0; bus.rptr = 4'b0110;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      check($sformatf("drain%0d_full", e), {31'd0, bus.full}, {31'd0, dr_full[e]});
      check($sformatf("drain%0d_wcount", e), {28'd0, bus.wcount}, dr_cnt[e]);
      check($sformatf("drain%0d_afull", e), {31'd0, bus.almost_full}, {31'd0, dr_full[e]});
      check($sformatf("drain%0d_ovf", e), {31'd0, bus.overflow}, {31'd0, OvfEn});
      @(negedge clk);
    end

    // Reset mid-operation with a write request pending.
    mstep(1, 0); mstep(1, 0);
    for (int k = 0; k < 5; k++) mstep(0, 1);
    check("mid_wcount5", {28'd0, bus.wcount}, 32'd5);
    mstep(1, 1);
    check("mid_rst_waddr", {29'd0, bus.waddr}, 32'd0);
    check("mid_rst_wptr", {28'd0, bus.wptr}, 32'd0);
    check("mid_rst_wcount", {28'd0, bus.wcount}, 32'd0);
    mstep(0, 0);
    check("mid_dropped_waddr", {29'd0, bus.waddr}, 32'd0);

    // Wrap: 20 writes with the reader keeping up, so full never asserts.
    mstep(1, 0);
    writes = 0; wraps = 0;
    for (int c = 0; c < 200 && writes < 20; c++) begin
      if (((m_wr - rd_bin + 16) % 16) >= 2) rd_bin = (rd_bin + 1) % 16;
      if (!m_full) begin
        writes++;
        if (m_wr % 8 == 7) wraps++;
      end
      mstep(0, 1);
      check("wrap_nofull", {31'd0, bus.full}, 32'd0);
    end
    check("wrap_writes", writes, 32'd20);
    check("wrap_count", wraps, 32'd2);

    // Random traffic with varying reader speed and occasional resets.
    rate = 2;
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 0) rate = int'($urandom_range(1, 4));
      if (((m_wr - rd_bin + 16) % 16) != 0 && $urandom_range(0, rate) == 0)
        rd_bin = (rd_bin + 1) % 16;
      mstep($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
